mesh_border_endpoint: RTL and testbench

Credit-based traffic endpoint that terminates one open border port of the manycore mesh (EAST/WEST/NORTH/SOUTH edge) in place of the constant grounding ties. It injects host-supplied Hermes packets into the adjacent router and ejects packets arriving from it, tracking packet framing (header, size, payload) in both directions. It sits directly beside a border router port, between that port and the test harness or off-chip bridge.

---
 rtl/manycore_border_pkg.sv | 63 ++++++
 rtl/border_flit_fifo.sv | 69 ++++++
 rtl/mesh_border_endpoint.sv | 124 ++++++++++++
 tb/tb_mesh_border_endpoint.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/manycore_border_pkg.sv
// Shared types and Hermes framing helpers for mesh border endpoints.
// Both framing FSMs (injection and ejection) step through frame_advance/frame_is_last.
package manycore_border_pkg;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    SIZE    = 2'd1,
    PAYLOAD = 2'd2
  } frame_state_t;

  typedef struct packed {
    frame_state_t state;
    logic [15:0]  remain;
  } frame_t;

  localparam frame_t FRAME_IDLE = '{state: HDR, remain: 16'd0};

  function automatic logic [7:0] hdr_x(input logic [15:0] hdr);
    return hdr[15:8];
  endfunction

  function automatic logic [7:0] hdr_y(input logic [15:0] hdr);
    return hdr[7:0];
  endfunction

  // field is the low 16 bits of the flit being framed
  function automatic logic frame_is_last(input frame_t f, input logic [15:0] field);
    logic last;
    case (f.state)
      SIZE:    last = (field == 16'd0);
      PAYLOAD: last = (f.remain == 16'd1);
      default: last = 1'b0;
    endcase
    return last;
  endfunction

  function automatic frame_t frame_advance(input frame_t f, input logic [15:0] field);
    frame_t n;
    n = f;
    case (f.state)
      HDR: n.state = SIZE;
      SIZE: begin
        n.remain = field;
        n.state  = (field == 16'd0) ? HDR : PAYLOAD;
      end
      PAYLOAD: begin
        n.remain = f.remain - 16'd1;
        n.state  = (f.remain == 16'd1) ? HDR : PAYLOAD;
      end
      default: n = FRAME_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/border_flit_fifo.sv
// Synchronous flit FIFO with registered not-full / not-empty flags.
// head is forced to zero while empty so downstream outputs stay clean.
module border_flit_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             not_full,
  output logic             not_empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             not_full_r;
  logic             not_empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualified handshakes and next occupancy
  always_comb begin
    do_push_s    = push && not_full_r;
    do_pop_s     = pop && not_empty_r;
    count_next_s = count_r + CW'(do_push_s) - CW'(do_pop_s);
  end

  // Storage array
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and flags; flags reflect occupancy after this edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      not_full_r  <= 1'b0;
      not_empty_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r     <= count_next_s;
      not_full_r  <= (count_next_s < CW'(DEPTH));
      not_empty_r <= (count_next_s != {CW{1'b0}});
    end
  end

  assign not_full  = not_full_r;
  assign not_empty = not_empty_r;
  assign head      = not_empty_r ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

endmodule

// File: rtl/mesh_border_endpoint.sv
// Credit-based endpoint terminating an open mesh border port: injects host
// packets toward the router and ejects router packets to the host, framing both.
module mesh_border_endpoint
  import manycore_border_pkg::*;
#(
  parameter int          FLIT_WIDTH = 32,
  parameter int          TX_DEPTH   = 4,
  parameter int          RX_DEPTH   = 4,
  parameter logic [31:0] ADDRESS    = 32'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FLIT_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic                  credit_i,
  output logic                  clock_tx,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  input  logic                  clock_rx,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FLIT_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  err_frame,
  output logic [15:0]           tx_pkts,
  output logic [15:0]           rx_pkts
);

  localparam int WW = FLIT_WIDTH + 1;

  logic          tx_push_s, tx_pop_s, tx_not_full_s, tx_not_empty_s;
  logic          rx_push_s, rx_pop_s, rx_not_full_s, rx_not_empty_s;
  logic [WW-1:0] tx_head_s, rx_head_s;
  logic          in_last_s, eg_last_s;
  frame_t        in_frame_r, eg_frame_r;
  logic          err_frame_r;
  logic [15:0]   tx_pkts_r, rx_pkts_r;
  logic          unused_s;

  // Handshakes and framing end-of-packet decisions
  always_comb begin
    tx_push_s = s_valid && tx_not_full_s;
    tx_pop_s  = tx_not_empty_s && credit_i;
    rx_push_s = rx && rx_not_full_s;
    rx_pop_s  = rx_not_empty_s && m_ready;
    in_last_s = frame_is_last(in_frame_r, s_data[15:0]);
    eg_last_s = frame_is_last(eg_frame_r, data_i[15:0]);
  end

  // Framing FSMs; a host-marked last always resynchronises ingress to HDR
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_frame_r  <= FRAME_IDLE;
      eg_frame_r  <= FRAME_IDLE;
      err_frame_r <= 1'b0;
    end else begin
      err_frame_r <= tx_push_s && (s_last != in_last_s);
      if (tx_push_s) begin
        in_frame_r <= s_last ? FRAME_IDLE : frame_advance(in_frame_r, s_data[15:0]);
      end
      if (rx_push_s) begin
        eg_frame_r <= frame_advance(eg_frame_r, data_i[15:0]);
      end
    end
  end

  // Packet counters advance when a last-marked flit leaves its FIFO
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_pkts_r <= 16'd0;
      rx_pkts_r <= 16'd0;
    end else begin
      if (tx_pop_s && tx_head_s[FLIT_WIDTH]) begin
        tx_pkts_r <= tx_pkts_r + 16'd1;
      end
      if (rx_pop_s && rx_head_s[FLIT_WIDTH]) begin
        rx_pkts_r <= rx_pkts_r + 16'd1;
      end
    end
  end

  border_flit_fifo #(.WIDTH(WW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push_s),
    .push_data ({s_last, s_data}),
    .pop       (tx_pop_s),
    .not_full  (tx_not_full_s),
    .not_empty (tx_not_empty_s),
    .head      (tx_head_s)
  );

  border_flit_fifo #(.WIDTH(WW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push_s),
    .push_data ({eg_last_s, data_i}),
    .pop       (rx_pop_s),
    .not_full  (rx_not_full_s),
    .not_empty (rx_not_empty_s),
    .head      (rx_head_s)
  );

  // ADDRESS is kept for future traffic tagging; clock_rx is the same domain as clock
  assign unused_s  = ^{clock_rx, ADDRESS};

  assign s_ready   = tx_not_full_s;
  assign tx        = tx_not_empty_s;
  assign data_o    = tx_head_s[FLIT_WIDTH-1:0];
  assign clock_tx  = clock;
  assign credit_o  = rx_not_full_s;
  assign m_valid   = rx_not_empty_s;
  assign m_data    = rx_head_s[FLIT_WIDTH-1:0];
  assign m_last    = rx_head_s[FLIT_WIDTH];
  assign err_frame = err_frame_r;
  assign tx_pkts   = tx_pkts_r;
  assign rx_pkts   = rx_pkts_r;

endmodule

// File: tb/tb_mesh_border_endpoint.sv
// Self-checking bench: queue-based packet model compared every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_mesh_border_endpoint;
  localparam int FW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0, credit_i = 1'b0, rx = 1'b0, m_ready = 1'b0;
  logic [FW-1:0] s_data = '0, data_i = '0;
  logic          s_ready, tx, clock_tx, credit_o, m_valid, m_last, err_frame;
  logic [FW-1:0] data_o, m_data;
  logic [15:0]   tx_pkts, rx_pkts;

  mesh_border_endpoint #(.FLIT_WIDTH(FW), .TX_DEPTH(4), .RX_DEPTH(4), .ADDRESS(32'h0)) dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .tx(tx), .data_o(data_o), .credit_i(credit_i), .clock_tx(clock_tx),
    .rx(rx), .data_i(data_i), .credit_o(credit_o), .clock_rx(clock), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .err_frame(err_frame),
    .tx_pkts(tx_pkts), .rx_pkts(rx_pkts)
  );

  initial forever #5 clock = ~clock;

  // Reference model: packet queues, flit index within packet, counters
  logic [FW:0] tq[$];
  logic [FW:0] rq[$];
  int          t_idx = 0, t_size = 0, r_idx = 0, r_size = 0;
  logic [15:0] m_txp = 16'd0, m_rxp = 16'd0;
  bit          m_srdy = 1'b0, m_crdt = 1'b0, m_err = 1'b0, s_took = 1'b0, r_took = 1'b0;
  int          errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index 0 = header, 1 = size, 2.. = payload; packet ends on size when S=0 else at index S+1
  function automatic bit frame_end(input int idx, input int size, input logic [FW-1:0] d);
    return (idx == 1 && d[15:0] == 16'd0) || (idx >= 2 && idx == size + 1);
  endfunction

  task automatic model_step();
    bit          push, pop, endp;
    logic [FW:0] h;
    if (!reset) begin
      tq.delete(); rq.delete();
      t_idx = 0; t_size = 0; r_idx = 0; r_size = 0;
      m_txp = 16'd0; m_rxp = 16'd0;
      m_srdy = 1'b0; m_crdt = 1'b0; m_err = 1'b0; s_took = 1'b0; r_took = 1'b0;
      return;
    end
    pop  = (tq.size() != 0) && credit_i;
    push = s_valid && m_srdy;
    s_took = push;
    m_err  = 1'b0;
    if (pop) begin
      h = tq.pop_front();
      if (h[FW]) m_txp = m_txp + 16'd1;
    end
    if (push) begin
      endp  = frame_end(t_idx, t_size, s_data);
      m_err = (s_last != endp);
      tq.push_back({s_last, s_data});
      if (s_last || endp) t_idx = 0;
      else begin
        if (t_idx == 1) t_size = int'(s_data[15:0]);
        t_idx++;
      end
    end
    m_srdy = (tq.size() < 4);
    pop  = (rq.size() != 0) && m_ready;
    push = rx && m_crdt;
    r_took = push;
    if (pop) begin
      h = rq.pop_front();
      if (h[FW]) m_rxp = m_rxp + 16'd1;
    end
    if (push) begin
      endp = frame_end(r_idx, r_size, data_i);
      rq.push_back({endp, data_i});
      if (endp) r_idx = 0;
      else begin
        if (r_idx == 1) r_size = int'(data_i[15:0]);
        r_idx++;
      end
    end
    m_crdt = (rq.size() < 4);
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    model_step();
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clock);
    chk("clock_tx", 64'(clock_tx), 64'(1'b0));
    chk("s_ready", 64'(s_ready), 64'(m_srdy));
    chk("credit_o", 64'(credit_o), 64'(m_crdt));
    chk("tx", 64'(tx), 64'(tq.size() != 0));
    chk("m_valid", 64'(m_valid), 64'(rq.size() != 0));
    chk("err_frame", 64'(err_frame), 64'(m_err));
    chk("tx_pkts", 64'(tx_pkts), 64'(m_txp));
    chk("rx_pkts", 64'(rx_pkts), 64'(m_rxp));
    if (tq.size() != 0) chk("data_o", 64'(data_o), 64'(tq[0][FW-1:0]));
    if (rq.size() != 0) begin
      chk("m_data", 64'(m_data), 64'(rq[0][FW-1:0]));
      chk("m_last", 64'(m_last), 64'(rq[0][FW]));
    end
    if (!reset) chk("reset_data", 64'({data_o, m_last, m_data}), 64'(0));
  end

  task automatic s_flit(input logic [FW-1:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clock);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic r_flit(input logic [FW-1:0] d);
    rx = 1'b1; data_i = d;
    @(negedge clock);
    rx = 1'b0;
  endtask

  logic [FW:0] pkt[$];
  logic [FW:0] s_pend[$];
  logic [FW:0] r_pend[$];

  task automatic gen_pkt();
    int          sz;
    logic [FW-1:0] tmp;
    pkt.delete();
    sz  = int'($urandom_range(0, 3));
    tmp = $urandom();
    pkt.push_back({1'b0, tmp});
    tmp = $urandom();
    tmp[15:0] = 16'(sz);
    pkt.push_back({(sz == 0), tmp});
    for (int i = 0; i < sz; i++) begin
      tmp = $urandom();
      pkt.push_back({(i == sz - 1), tmp});
    end
  endtask

  initial begin
    logic [FW-1:0] exp_rx [4];
    bit            s_cut;
    repeat (3) @(negedge clock);
    chk("rst_ready", 64'({s_ready, credit_o, tx, m_valid, err_frame}), 64'(0));
    chk("rst_cnt", 64'({tx_pkts, rx_pkts}), 64'(0));
    reset = 1'b1;
    @(negedge clock);
    chk("first_ready", 64'({s_ready, credit_o}), 64'(2'b11));

    // 4-flit packet under constant credit
    credit_i = 1'b1;
    s_flit(32'h0101, 1'b0); chk("t1_hdr", 64'(data_o), 64'(32'h0101));
    s_flit(32'd2, 1'b0);    chk("t1_size", 64'(data_o), 64'(32'd2));
    s_flit(32'hA, 1'b0);    chk("t1_a", 64'(data_o), 64'(32'hA));
    s_flit(32'hB, 1'b1);    chk("t1_b", 64'({tx, data_o}), 64'({1'b1, 32'hB}));
    @(negedge clock);
    chk("t1_pkts", 64'({tx, tx_pkts}), 64'({1'b0, 16'd1}));

    // Credit stall after the header; FIFO fills
    s_flit(32'h0101, 1'b0);
    s_flit(32'd2, 1'b0);    chk("t2_held", 64'(data_o), 64'(32'd2));
    credit_i = 1'b0;
    s_flit(32'hA, 1'b0);
    s_flit(32'hB, 1'b1);
    s_flit(32'h0303, 1'b0);
    chk("t2_full", 64'({s_ready, tx, data_o}), 64'({1'b0, 1'b1, 32'd2}));
    repeat (2) @(negedge clock);
    credit_i = 1'b1;
    repeat (6) @(negedge clock);
    s_flit(32'd0, 1'b1);
    repeat (2) @(negedge clock);
    chk("t2_pkts", 64'(tx_pkts), 64'(16'd3));

    // Size-0 packet is clean; early s_last pulses err_frame once
    s_flit(32'h0404, 1'b0);
    s_flit(32'd0, 1'b1);    chk("t3_noerr", 64'(err_frame), 64'(1'b0));
    s_flit(32'h0505, 1'b0);
    s_flit(32'd2, 1'b0);
    s_flit(32'hA, 1'b1);    chk("t3_err", 64'(err_frame), 64'(1'b1));
    @(negedge clock);       chk("t3_pulse", 64'(err_frame), 64'(1'b0));
    repeat (3) @(negedge clock);
    chk("t3_pkts", 64'(tx_pkts), 64'(16'd5));

    // Ejection backpressure, dropped flit, drain
    m_ready = 1'b0;
    exp_rx[0] = 32'h0202; exp_rx[1] = 32'd3; exp_rx[2] = 32'h11; exp_rx[3] = 32'h22;
    for (int i = 0; i < 4; i++) r_flit(exp_rx[i]);
    chk("t4_full", 64'({credit_o, m_valid, m_data}), 64'({1'b0, 1'b1, 32'h0202}));
    r_flit(32'hDEAD);
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", 64'({m_last, m_data}), 64'({1'b0, exp_rx[i]}));
      m_ready = 1'b1;
      @(negedge clock);
    end
    chk("t4_empty", 64'(m_valid), 64'(1'b0));
    r_flit(32'h33);
    chk("t4_last", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b1, 32'h33}));
    @(negedge clock);
    chk("t4_pkts", 64'(rx_pkts), 64'(16'd1));

    // Reset in the middle of both packets
    credit_i = 1'b0; m_ready = 1'b0;
    s_flit(32'h0606, 1'b0); s_flit(32'd3, 1'b0); s_flit(32'h61, 1'b0);
    r_flit(32'h0707); r_flit(32'd3); r_flit(32'h71);
    s_valid = 1'b1; s_data = 32'h62; rx = 1'b1; data_i = 32'h72;
    #2 reset = 1'b0;
    #1;
    chk("t5_ctl", 64'({tx, s_ready, credit_o, m_valid, m_last, err_frame}), 64'(0));
    chk("t5_data", 64'({data_o, m_data}), 64'(0));
    chk("t5_cnt", 64'({tx_pkts, rx_pkts}), 64'(0));
    s_valid = 1'b0; rx = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_ready", 64'({s_ready, credit_o, tx, m_valid}), 64'(4'b1100));
    credit_i = 1'b1; m_ready = 1'b1;
    s_flit(32'h0808, 1'b0);
    s_flit(32'd0, 1'b1);    chk("t5_frame", 64'(err_frame), 64'(1'b0));
    @(negedge clock);       chk("t5_tx_pkts", 64'(tx_pkts), 64'(16'd1));
    r_flit(32'h0909);
    r_flit(32'd0);          chk("t5_rx_last", 64'({m_last, m_data}), 64'({1'b1, 32'd0}));
    @(negedge clock);       chk("t5_rx_pkts", 64'(rx_pkts), 64'(16'd1));

    // Randomized traffic on both sides
    s_cut = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (s_valid && s_took) begin
        if (s_cut) s_pend.delete();
        else s_pend.delete(0);
      end
      if (rx && r_took) r_pend.delete(0);
      if (s_pend.size() == 0) begin gen_pkt(); s_pend = pkt; end
      if (r_pend.size() == 0) begin gen_pkt(); r_pend = pkt; end
      s_cut    = ($urandom_range(0, 11) == 0);
      s_valid  = ($urandom_range(0, 3) != 0);
      s_data   = s_pend[0][FW-1:0];
      s_last   = s_pend[0][FW] ^ s_cut;
      rx       = ($urandom_range(0, 3) != 0);
      data_i   = r_pend[0][FW-1:0];
      credit_i = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 1) != 0);
      @(negedge clock);
    end
    s_valid = 1'b0; rx = 1'b0; credit_i = 1'b1; m_ready = 1'b1;
    repeat (20) @(negedge clock);
    chk("end_drained", 64'({tx, m_valid}), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
